// File: rtl/keypad_scanner.sv
// keypad_scanner: row-scanned key matrix with full-scan debounce and a key-event FIFO
module keypad_scanner #(
  parameter int ROWS = 4,
  parameter int COLS = 3,
  parameter int SETTLE = 4,
  parameter int DEBOUNCE = 3,
  parameter int FIFO_DEPTH = 4,
  localparam int N = ROWS * COLS,
  localparam int KW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [COLS-1:0] column,
  output logic [ROWS-1:0] row,
  output logic [N-1:0]    state,
  output logic            ev_valid,
  input  logic            ev_ready,
  output logic [KW-1:0]   ev_code,
  output logic            ev_press,
  output logic            overflow,
  input  logic            ov_clear
);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [RW-1:0] r, r_nxt;
  logic [SW-1:0] s;
  logic [N-1:0]  raw, last, snap, diff, diff_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          sample, scan_end, commit, emit, full, pop, wr, drop;
  logic [KW-1:0] k;
  logic [AW:0]   wptr, rptr;
  logic [KW:0]   mem [FIFO_DEPTH];
  always_comb begin
    sample = s == SW'(SETTLE - 1);
    scan_end = sample && r == RW'(ROWS - 1);
    r_nxt = sample ? (scan_end ? '0 : r + 1'b1) : r;
    snap = raw;
    snap[r*COLS +: COLS] = column;
    cnt_nxt = snap != last ? CW'(1) : (cnt == CW'(DEBOUNCE) ? cnt : cnt + 1'b1);
    commit = scan_end && cnt_nxt == CW'(DEBOUNCE) && snap != state;
    k = '0;
    for (int i = N - 1; i >= 0; i--) if (diff[i]) k = KW'(i);
    diff_nxt = diff & ~(N'(1) << k);
    full = wptr == (rptr ^ (AW + 1)'(FIFO_DEPTH));
    ev_valid = wptr != rptr;
    pop = ev_valid && ev_ready;
    wr = emit && (!full || pop);
    drop = emit && full && !pop;
    {ev_code, ev_press} = ev_valid ? mem[rptr[AW-1:0]] : '0;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r <= '0;
      s <= '0;
      row <= ROWS'(1);
      raw <= '0;
      last <= '0;
      cnt <= '0;
      state <= '0;
      emit <= 1'b0;
      diff <= '0;
      wptr <= '0;
      rptr <= '0;
      overflow <= 1'b0;
    end else begin
      s <= sample ? '0 : s + 1'b1;
      r <= r_nxt;
      row <= ROWS'(1) << r_nxt;
      if (sample) raw <= snap;
      if (scan_end) begin
        cnt <= cnt_nxt;
        last <= snap;
      end
      if (commit) begin
        state <= snap;
        diff <= state ^ snap;
        emit <= 1'b1;
      end else if (emit) begin
        diff <= diff_nxt;
        emit <= |diff_nxt;
      end
      if (wr) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      overflow <= drop | (overflow & ~ov_clear);
    end
  end
  // state already holds the committed snapshot while emitting, so it supplies the press bit
  always_ff @(posedge clock) begin
    if (wr) mem[wptr[AW-1:0]] <= {k, state[k]};
  end
endmodule
